hazard_stall_unit: RTL



---
 rtl/hazard_stall_if.sv | 44 ++++
 rtl/hazard_stall_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_if.sv
// Control bundle between the pipeline and the hazard/stall unit.
// The pipeline (master) supplies the hazard inputs; the unit (slave) returns the stage controls.
interface hazard_stall_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rs;
  logic [3:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             branch_taken;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [3:0]       ex_rt_rd;
  logic             exmem_memread;
  logic [3:0]       exmem_rd;
  logic             exmem_mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
           idex_memread, idex_regwrite, ex_rt_rd, exmem_memread, exmem_rd,
           exmem_mem_req, mem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_bubble, memwb_bubble, mem_timeout, stall_cycles
  );

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
           idex_memread, idex_regwrite, ex_rt_rd, exmem_memread, exmem_rd,
           exmem_mem_req, mem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
           idex_bubble, memwb_bubble, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall sequencing for the five-stage 16-bit pipeline:
// load-use stalls, ID-branch-after-load stalls, data-memory wait freezes and a stall-cycle counter.
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_stall_if.slave hz
);
  localparam int                WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] W_TMO  = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_stall_cnt, w_stall_cnt_nxt;
  logic [1:0]        r_pend, w_pend_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic       w_hit_ex, w_hit_mem, w_memwait;
  logic [1:0] w_need;
  logic       w_pc_write, w_ifid_write, w_idex_write, w_exmem_write;
  logic       w_ifid_flush, w_idex_bubble, w_memwb_bubble;

  assign w_hit_ex  = hz.idex_regwrite && (hz.ex_rt_rd != 4'd0) &&
                     ((hz.id_uses_rs && (hz.ex_rt_rd == hz.id_rs)) ||
                      (hz.id_uses_rt && (hz.ex_rt_rd == hz.id_rt)));
  assign w_hit_mem = hz.exmem_memread && (hz.exmem_rd != 4'd0) &&
                     ((hz.id_uses_rs && (hz.exmem_rd == hz.id_rs)) ||
                      (hz.id_uses_rt && (hz.exmem_rd == hz.id_rt)));
  assign w_memwait = hz.exmem_mem_req && !hz.mem_ready;

  always_comb begin
    w_need = 2'd0;
    if (hz.idex_memread && w_hit_ex)          w_need = hz.id_is_branch ? 2'd2 : 2'd1;
    else if (hz.id_is_branch && w_hit_mem)    w_need = 2'd1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_pend_nxt      = r_pend;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_pc_write      = 1'b1;
    w_ifid_write    = 1'b1;
    w_idex_write    = 1'b1;
    w_exmem_write   = 1'b1;
    w_ifid_flush    = 1'b0;
    w_idex_bubble   = 1'b0;
    w_memwb_bubble  = 1'b0;

    if (w_memwait && (r_state != MEM_WAIT)) begin
      // Entering a wait freezes everything; owed stall cycles are parked in pend.
      {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
      w_memwb_bubble = 1'b1;
      w_state_nxt    = MEM_WAIT;
      w_wait_cnt_nxt = WAIT_W'(1);
      w_pend_nxt     = (r_state == STALL) ? r_stall_cnt : 2'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_need != 2'd0) begin
            {w_pc_write, w_ifid_write} = 2'b00;
            w_idex_bubble = 1'b1;
            if (w_need == 2'd2) begin
              w_state_nxt     = STALL;
              w_stall_cnt_nxt = 2'd1;
            end
          end else if (hz.id_is_branch && hz.branch_taken) begin
            w_ifid_flush = 1'b1;
          end
        end
        STALL: begin
          {w_pc_write, w_ifid_write} = 2'b00;
          w_idex_bubble = 1'b1;
          if (r_stall_cnt > 2'd1) begin
            w_stall_cnt_nxt = r_stall_cnt - 2'd1;
          end else begin
            w_stall_cnt_nxt = 2'd0;
            w_state_nxt     = RUN;
          end
        end
        MEM_WAIT: begin
          if (w_memwait) begin
            {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
            w_memwb_bubble = 1'b1;
            if (r_wait_cnt != W_TMO) w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end else begin
            // Back end drains this cycle; ID is only re-examined once back in RUN.
            w_wait_cnt_nxt = '0;
            w_state_nxt    = RUN;
            if (r_pend != 2'd0) begin
              {w_pc_write, w_ifid_write} = 2'b00;
              w_idex_bubble = 1'b1;
              w_pend_nxt    = r_pend - 2'd1;
              if (r_pend > 2'd1) begin
                w_state_nxt     = STALL;
                w_stall_cnt_nxt = r_pend - 2'd1;
              end
            end
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_stall_cnt    <= 2'd0;
      r_pend         <= 2'd0;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_pend      <= w_pend_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      if (w_wait_cnt_nxt == W_TMO) r_mem_timeout <= 1'b1;
      if (!w_pc_write && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Reset holds the whole pipeline frozen and bubbled.
  assign hz.pc_write     = rst_n & w_pc_write;
  assign hz.ifid_write   = rst_n & w_ifid_write;
  assign hz.idex_write   = rst_n & w_idex_write;
  assign hz.exmem_write  = rst_n & w_exmem_write;
  assign hz.ifid_flush   = !rst_n | w_ifid_flush;
  assign hz.idex_bubble  = !rst_n | w_idex_bubble;
  assign hz.memwb_bubble = !rst_n | w_memwb_bubble;
  assign hz.mem_timeout  = r_mem_timeout;
  assign hz.stall_cycles = r_stall_cycles;
endmodule
